// File: rtl/pipeline_defs.sv
// Shared pipeline constants: writeback control field layout,
// the hardwired-zero register index and default datapath widths.
package pipeline_defs;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    localparam int WB_WIDTH    = 2;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bundle plus the ID read ports and the
// writeback bus exported to forwarding.
interface wb_regfile_if
    import pipeline_defs::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic [WB_WIDTH-1:0]   WBRegister;
    logic [DATA_WIDTH-1:0] memRegister;
    logic [DATA_WIDTH-1:0] ALURegister;
    logic [ADDR_WIDTH-1:0] rdRegister;
    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic [DATA_WIDTH-1:0] wbData;
    logic [ADDR_WIDTH-1:0] wbReg;
    logic                  wbEnable;

    modport master (
        output WBRegister, memRegister, ALURegister, rdRegister, rs, rt,
        input  readData1, readData2, wbData, wbReg, wbEnable
    );

    modport slave (
        input  WBRegister, memRegister, ALURegister, rdRegister, rs, rt,
        output readData1, readData2, wbData, wbReg, wbEnable
    );

endinterface

// File: rtl/wb_mux.sv
// 2:1 writeback selector; shared with the forwarding unit.
module wb_mux #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] alu_data,
    output logic [WIDTH-1:0] wb_data
);

    assign wb_data = sel ? mem_data : alu_data;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry architectural register file with
// write-through bypass on both ID read ports.
module wb_regfile
    import pipeline_defs::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic          clock,
    input logic          reset,
    wb_regfile_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [DEPTH] = '{default: '0};

    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wb_data;

    assign reg_write  = bus.WBRegister[WB_REGWRITE];
    assign mem_to_reg = bus.WBRegister[WB_MEMTOREG];
    assign wr_en      = reg_write && (bus.rdRegister != ZERO_IDX);

    wb_mux #(
        .WIDTH (DATA_WIDTH)
    ) u_wb_mux (
        .sel      (mem_to_reg),
        .mem_data (bus.memRegister),
        .alu_data (bus.ALURegister),
        .wb_data  (wb_data)
    );

    assign bus.wbData   = wb_data;
    assign bus.wbReg    = bus.rdRegister;
    assign bus.wbEnable = wr_en;

    // r0 reads as zero regardless of any pending writeback
    assign bus.readData1 =
        (bus.rs == ZERO_IDX) ? '0 :
        (wr_en && bus.rs == bus.rdRegister) ? wb_data :
        regs[bus.rs];

    assign bus.readData2 =
        (bus.rt == ZERO_IDX) ? '0 :
        (wr_en && bus.rt == bus.rdRegister) ? wb_data :
        regs[bus.rt];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.rdRegister] <= wb_data;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed plan cases followed by
// random traffic checked against an array model of the register file.
module tb_wb_regfile;

    logic clock = 1'b0;
    logic reset = 1'b0;

    wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    wb_regfile #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wbd;
        logic [4:0]  wbr;
        logic        en;
    } exp_t;

    exp_t        sb [$];
    int unsigned model [32];
    int          checks   = 0;
    int          failures = 0;

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int unsigned model_read(input int idx, input bit en,
                                               input int rd,
                                               input int unsigned wbd);
        if (idx == 0) return 0;
        if (en && idx == rd) return wbd;
        return model[idx];
    endfunction

    // Drive one cycle of inputs, predict outputs, then commit to the model
    task automatic step(input string name, input bit rst, input bit [1:0] wb,
                        input int unsigned mem, input int unsigned alu,
                        input int rd, input int rs, input int rt);
        exp_t        e;
        int unsigned wbd;
        bit          en;
        @(posedge clock);
        #1;
        reset           = rst;
        bus.WBRegister  = wb;
        bus.memRegister = mem;
        bus.ALURegister = alu;
        bus.rdRegister  = 5'(rd);
        bus.rs          = 5'(rs);
        bus.rt          = 5'(rt);
        wbd    = wb[0] ? mem : alu;
        en     = wb[1] && (rd != 0);
        e.name = name;
        e.wbd  = wbd;
        e.wbr  = 5'(rd);
        e.en   = en;
        e.rd1  = model_read(rs, en, rd, wbd);
        e.rd2  = model_read(rt, en, rd, wbd);
        sb.push_back(e);
        if (rst) begin
            foreach (model[i]) model[i] = 0;
        end else if (en) begin
            model[rd] = wbd;
        end
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp({e.name, ".readData1"}, bus.readData1, e.rd1);
            cmp({e.name, ".readData2"}, bus.readData2, e.rd2);
            cmp({e.name, ".wbData"}, bus.wbData, e.wbd);
            cmp({e.name, ".wbReg"}, {27'd0, bus.wbReg}, {27'd0, e.wbr});
            cmp({e.name, ".wbEnable"}, {31'd0, bus.wbEnable}, {31'd0, e.en});
        end
    end

    initial begin
        int rd;
        int rs;
        int rt;
        foreach (model[i]) model[i] = 0;
        bus.WBRegister  = 2'b00;
        bus.memRegister = '0;
        bus.ALURegister = '0;
        bus.rdRegister  = '0;
        bus.rs          = '0;
        bus.rt          = '0;

        step("reset",      1, 2'b00, 0, 0, 0, 0, 0);
        step("rst_read",   0, 2'b00, 0, 0, 0, 5, 31);
        step("alu_wr",     0, 2'b10, 32'h0, 32'h0000_1234, 7, 7, 0);
        step("alu_rd",     0, 2'b00, 0, 0, 0, 7, 0);
        step("ld_wr",      0, 2'b11, 32'hDEAD_BEEF, 32'h1, 12, 0, 12);
        step("ld_rd",      0, 2'b00, 0, 0, 0, 0, 12);
        step("r0_wr",      0, 2'b10, 0, 32'hFFFF_FFFF, 0, 0, 0);
        step("r0_rd",      0, 2'b00, 0, 0, 0, 0, 0);
        step("byp_pre",    0, 2'b10, 0, 32'h11, 3, 0, 0);
        step("byp_same",   0, 2'b10, 0, 32'h22, 3, 3, 3);
        step("byp_after",  0, 2'b00, 0, 0, 0, 3, 3);
        step("col_pre",    0, 2'b10, 0, 32'h55, 9, 0, 0);
        step("col_edge",   1, 2'b10, 0, 32'h99, 9, 9, 0);
        step("col_rd",     0, 2'b00, 0, 0, 0, 9, 7);
        step("nowr_pre",   0, 2'b10, 0, 32'h55, 9, 0, 0);
        step("nowr",       0, 2'b00, 0, 32'h77, 9, 9, 0);
        step("nowr_rd",    0, 2'b00, 0, 0, 0, 9, 9);

        for (int n = 0; n < 400; n++) begin
            rd = int'($urandom_range(31));
            rs = ($urandom_range(3) == 0) ? rd : int'($urandom_range(31));
            rt = ($urandom_range(3) == 0) ? rd : int'($urandom_range(31));
            step("rand", ($urandom_range(40) == 0), 2'($urandom),
                 $urandom, $urandom, rd, rs, rt);
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback stage plus architectural register file for the 5-stage pipeline.
- Consumes the MEM/WB pipeline register outputs: control pair, memory data, ALU result, destination register.
- Selects the writeback value and commits it to a 32-entry register file on the clock edge.
- Provides the two ID-stage read ports, with write-through bypass.
- Exports the writeback bus to the forwarding unit.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, register index width; the file has 2**ADDR_WIDTH entries.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- WBRegister  in  2  writeback control. Bit 1 = RegWrite; bit 0 = MemtoReg (1 selects memory data).
- memRegister  in  DATA_WIDTH  load data from MEM/WB.
- ALURegister  in  DATA_WIDTH  ALU result from MEM/WB.
- rdRegister  in  ADDR_WIDTH  destination register index.
- rs  in  ADDR_WIDTH  read port 1 index (ID stage).
- rt  in  ADDR_WIDTH  read port 2 index (ID stage).
- readData1  out  DATA_WIDTH  contents of rs, bypassed.
- readData2  out  DATA_WIDTH  contents of rt, bypassed.
- wbData  out  DATA_WIDTH  selected writeback value, to the forwarding mux.
- wbReg  out  ADDR_WIDTH  equals rdRegister.
- wbEnable  out  1  effective write enable: RegWrite AND rdRegister != 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Writeback select (combinational): wbData = MemtoReg ? memRegister : ALURegister.
- wbReg and wbEnable are combinational from the inputs, with no added latency.
- Write path:
  - On posedge clock with reset=0 and wbEnable=1, regs[rdRegister] <= wbData.
  - Otherwise the register array holds.
- Register 0:
  - Hardwired zero. It is never written, and a read of index 0 always returns 0, even when WB targets r0 with RegWrite=1.
- Reset:
  - On posedge clock with reset=1, all entries become 0 in that single cycle.
  - Reset takes priority over a simultaneous write; that write is dropped.
  - Reset asserted mid-stream discards the in-flight writeback.
  - The register array is also initialised to 0 at time zero, matching existing pipeline registers.
- Outputs under reset: the combinational outputs follow their inputs. readData1/readData2 return 0 for all indices from the cycle after reset is sampled.
- Read ports (combinational, zero latency):
  - readDataN = 0 if index == 0.
  - Else wbData if wbEnable and index == rdRegister (write-before-read bypass, so ID sees a value written in the same cycle).
  - Else regs[index].
- Both ports may read the same index, and that index may equal rdRegister; each port applies the bypass independently.
- Back-to-back writes to the same rd on consecutive cycles: the last write wins; the read in each cycle sees that cycle's wbData.
- Unknown or X values on WBRegister are not specified; the bench drives only defined values.

Decomposition:
- Shared package (pipeline_defs):
  - WB field bit positions: WB_REGWRITE=1, WB_MEMTOREG=0.
  - REG_ZERO=0.
  - Default DATA_WIDTH/ADDR_WIDTH.
  - The same constants are used by id_ex, ex_mem and mem_wb.
- One sub-module: wb_mux, the 2:1 writeback selector, reused later by the forwarding unit.
- The register array and bypass logic stay in wb_regfile.

Test Plan:
- Reset then read: assert reset 1 cycle, then rs=5, rt=31 -> readData1=0, readData2=0.
- ALU writeback: WB=2'b10, ALURegister=0x0000_1234, rd=7, one edge; then rs=7 -> readData1=0x0000_1234. wbData is 0x1234 during the write cycle.
- Load writeback: WB=2'b11, memRegister=0xDEAD_BEEF, ALURegister=0x1, rd=12 -> wbData=0xDEADBEEF; after the edge, rt=12 -> readData2=0xDEADBEEF.
- r0 protection: WB=2'b10, ALURegister=0xFFFF_FFFF, rd=0 -> wbEnable=0; readData1 with rs=0 is 0 both in that cycle and after the edge.
- Same-cycle bypass: regs[3]=0x11 beforehand; WB=2'b10, ALU=0x22, rd=3, rs=rt=3 -> readData1=readData2=0x22 before the edge, and still 0x22 after it.
- Reset collision: regs[9]=0x55; same edge with reset=1 and WB=2'b10, rd=9, ALU=0x99 -> after the edge, rs=9 reads 0 (not 0x99). RegWrite=0 with rd=9, ALU=0x77 also leaves regs[9] unchanged.
